// File: rtl/aidc_lite_cmdq_pkg.sv
// Shared definitions for the AIDC-Lite descriptor queue.
//   - APB register offsets and STATUS / CTRL bit positions
//   - cmd_desc_t: one staged descriptor {src, dst, len}
//   - dispatch_state_t: dispatch FSM encoding, also exported on dbg_state
//   - fill_count_field(): squeezes the FIFO fill into the 8-bit COUNT field
package aidc_lite_cmdq_pkg;

  // Descriptor fields are staged through 32-bit APB registers.
  localparam int DESC_ADDR_W = 32;
  localparam int DESC_LEN_W  = 32;

  localparam logic [11:0] REG_SRC    = 12'h000;
  localparam logic [11:0] REG_DST    = 12'h004;
  localparam logic [11:0] REG_LEN    = 12'h008;
  localparam logic [11:0] REG_PUSH   = 12'h00C;
  localparam logic [11:0] REG_STATUS = 12'h010;
  localparam logic [11:0] REG_COUNT  = 12'h014;
  localparam logic [11:0] REG_CTRL   = 12'h018;

  localparam int ST_DONE  = 0;
  localparam int ST_BUSY  = 1;
  localparam int ST_EMPTY = 2;
  localparam int ST_FULL  = 3;
  localparam int ST_OVF   = 4;

  localparam int CTRL_IE   = 0;
  localparam int CTRL_OVF  = 4;
  localparam int CTRL_PEND = 8;

  typedef struct packed {
    logic [DESC_ADDR_W-1:0] src;
    logic [DESC_ADDR_W-1:0] dst;
    logic [DESC_LEN_W-1:0]  len;
  } cmd_desc_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OFFER = 2'd1,
    RUN   = 2'd2
  } dispatch_state_t;

  // COUNT[23:16] is 8 bits wide; a 256-entry FIFO that is full reads 0xFF.
  function automatic logic [7:0] fill_count_field(input logic [31:0] fill);
    return (fill > 32'd255) ? 8'hFF : fill[7:0];
  endfunction

endpackage

// File: rtl/aidc_lite_cmd_fifo.sv
// Synchronous descriptor FIFO.
//   clk, rst_n : clock, asynchronous active-low reset (pointers only)
//   push/wdata : write one descriptor; caller guarantees fill < DEPTH
//   pop        : drop the head; caller guarantees fill > 0
//   head       : current head entry (valid when fill > 0)
//   fill       : number of stored entries, 0..DEPTH
// Pointers carry one extra wrap bit so fill is a plain subtraction.
module aidc_lite_cmd_fifo
  import aidc_lite_cmdq_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  cmd_desc_t                wdata,
  input  logic                     pop,
  output cmd_desc_t                head,
  output logic [$clog2(DEPTH):0]   fill
);

  localparam int AW = $clog2(DEPTH);

  cmd_desc_t     mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: entries are only read once fill covers them.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  assign head = mem[rd_ptr[AW-1:0]];
  assign fill = wr_ptr - rd_ptr;

endmodule

// File: rtl/aidc_lite_cmd_queue.sv
// APB-programmed descriptor queue in front of the AIDC-Lite engine.
// Software stages SRC/DST/LEN, writes PUSH, and the block dispatches
// descriptors one at a time, counting completions.
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   psel/penable/pwrite/paddr/pwdata   APB request (zero wait states)
//   prdata/pready/pslverr              APB response
//   cmd_valid/cmd_ready                descriptor handshake to the engine
//   cmd_src/cmd_dst/cmd_len            descriptor payload
//   cmd_done                           1-cycle completion pulse from engine
//   irq                                level interrupt
//   dbg_state                          dispatch FSM state
// Optional feature macro: AIDC_CMDQ_IRQ_EN (IE/IRQ_PEND in CTRL, irq output).
// ADDR_W and LEN_W must not exceed 32 (the APB staging width).
//
// Handshake: a descriptor transfers on a cycle where cmd_valid && cmd_ready;
// while cmd_valid is high and cmd_ready low, cmd_valid and cmd_src/dst/len
// hold their values. cmd_done is honoured only while a descriptor runs.
module aidc_lite_cmd_queue
  import aidc_lite_cmdq_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [11:0]       paddr,
  input  logic [31:0]       pwdata,
  output logic [31:0]       prdata,
  output logic              pready,
  output logic              pslverr,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [ADDR_W-1:0] cmd_src,
  output logic [ADDR_W-1:0] cmd_dst,
  output logic [LEN_W-1:0]  cmd_len,
  input  logic              cmd_done,
  output logic              irq,
  output dispatch_state_t   dbg_state
);

  localparam int                FILL_W    = $clog2(DEPTH) + 1;
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(DEPTH);

  logic [31:0]       src_q, dst_q, len_q;
  logic              acc_wr, acc_rd;
  logic              push_req, push_full_err, push_len_err, push_ok;
  logic              ctrl_wr;
  logic              fifo_pop, fifo_empty, fifo_full;
  logic              done_acc;
  logic [FILL_W-1:0] fill;
  cmd_desc_t         fifo_head;
  cmd_desc_t         fifo_wdata;
  dispatch_state_t   state;
  logic              busy_q, done_q, ovf_q;
  logic [15:0]       completed_q;
  logic [31:0]       ctrl_rd;
  logic [31:0]       rd_data;

  assign acc_wr = psel & penable & pwrite;
  assign acc_rd = psel & ~pwrite;
  assign ctrl_wr = acc_wr & (paddr == REG_CTRL);

  assign fifo_empty = (fill == '0);
  assign fifo_full  = (fill == FILL_FULL);

  // Full is judged on the registered fill, so a pop in the same cycle
  // does not rescue a push into a full queue.
  assign push_req      = acc_wr & (paddr == REG_PUSH) & pwdata[0];
  assign push_full_err = push_req & fifo_full;
  assign push_len_err  = push_req & (len_q == 32'd0);
  assign push_ok       = push_req & ~fifo_full & (len_q != 32'd0);

  assign pready  = 1'b1;
  assign pslverr = push_full_err | push_len_err;

  assign fifo_pop = (state == OFFER) & cmd_ready;
  assign done_acc = (state == RUN) & cmd_done;

  assign fifo_wdata = '{src: src_q, dst: dst_q, len: len_q};

  aidc_lite_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_ok),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .head  (fifo_head),
    .fill  (fill)
  );

  // Staging registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q <= '0;
      dst_q <= '0;
      len_q <= '0;
    end else if (acc_wr) begin
      if (paddr == REG_SRC) src_q <= pwdata;
      if (paddr == REG_DST) dst_q <= pwdata;
      if (paddr == REG_LEN) len_q <= pwdata;
    end
  end

  // Dispatch FSM. The head is latched into the cmd_* registers on entry to
  // OFFER, which keeps the payload stable for the whole offer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cmd_valid   <= 1'b0;
      cmd_src     <= '0;
      cmd_dst     <= '0;
      cmd_len     <= '0;
      busy_q      <= 1'b0;
      completed_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            state     <= OFFER;
            cmd_valid <= 1'b1;
            cmd_src   <= fifo_head.src[ADDR_W-1:0];
            cmd_dst   <= fifo_head.dst[ADDR_W-1:0];
            cmd_len   <= fifo_head.len[LEN_W-1:0];
          end
        end
        OFFER: begin
          if (cmd_ready) begin
            state     <= RUN;
            cmd_valid <= 1'b0;
            busy_q    <= 1'b1;
          end
        end
        RUN: begin
          if (cmd_done) begin
            state       <= IDLE;
            busy_q      <= 1'b0;
            completed_q <= completed_q + 16'd1;
          end
        end
        default: begin
          state     <= IDLE;
          cmd_valid <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  // DONE: last completion drained the queue; an accepted push wins over a
  // same-cycle completion. OVF: sticky, cleared by W1C in CTRL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      if (push_ok)                       done_q <= 1'b0;
      else if (done_acc && fifo_empty)   done_q <= 1'b1;
      if (push_full_err)                 ovf_q  <= 1'b1;
      else if (ctrl_wr && pwdata[CTRL_OVF]) ovf_q <= 1'b0;
    end
  end

`ifdef AIDC_CMDQ_IRQ_EN
  logic ie_q, pend_q;
  logic ie_d, pend_d;

  // A completion in the same cycle as the W1C of IRQ_PEND keeps it set,
  // so no completion event is lost.
  always_comb begin
    ie_d   = ie_q;
    pend_d = pend_q;
    if (ctrl_wr) begin
      ie_d = pwdata[CTRL_IE];
      if (pwdata[CTRL_PEND]) pend_d = 1'b0;
    end
    if (done_acc) pend_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ie_q   <= 1'b0;
      pend_q <= 1'b0;
      irq    <= 1'b0;
    end else begin
      ie_q   <= ie_d;
      pend_q <= pend_d;
      irq    <= ie_d & pend_d;
    end
  end

  assign ctrl_rd = {23'd0, pend_q, 7'd0, ie_q};
`else
  assign irq     = 1'b0;
  assign ctrl_rd = 32'd0;
`endif

  // Read mux; driven only while a read is selected so the bus idles at 0.
  always_comb begin
    rd_data = 32'd0;
    if (acc_rd) begin
      case (paddr)
        REG_SRC:    rd_data = src_q;
        REG_DST:    rd_data = dst_q;
        REG_LEN:    rd_data = len_q;
        REG_STATUS: rd_data = {27'd0, ovf_q, fifo_full, fifo_empty, busy_q, done_q};
        REG_COUNT:  rd_data = {8'd0, fill_count_field(32'(fill)), completed_q};
        REG_CTRL:   rd_data = ctrl_rd;
        default:    rd_data = 32'd0;
      endcase
    end
  end

  assign prdata    = rd_data;
  assign dbg_state = state;

endmodule

// File: tb/tb_aidc_lite_cmd_queue.sv
// Testbench for aidc_lite_cmd_queue (DEPTH=8). A monitor process compares
// every APB response and every dispatched descriptor against a queue-based
// reference model; directed sequences cover the listed scenarios.
module tb_aidc_lite_cmd_queue;
  import aidc_lite_cmdq_pkg::*;

  localparam int DEPTH = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            psel, penable, pwrite;
  logic [11:0]     paddr;
  logic [31:0]     pwdata;
  logic [31:0]     prdata;
  logic            pready, pslverr;
  logic            cmd_valid;
  logic            cmd_ready = 1'b0;
  logic [31:0]     cmd_src, cmd_dst, cmd_len;
  logic            cmd_done;
  logic            irq;
  dispatch_state_t dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  int ready_mode = 0;   // 0: low, 1: high, 2: random
  int done_delay = 3;   // cycles from accept to cmd_done
  int inject_req = 0;   // stray cmd_done requests
  int inject_ack = 0;

  // Reference model
  logic [95:0] exp_q[$];
  logic [31:0] m_src, m_dst, m_len;
  logic        m_busy, m_done, m_ovf, m_ie, m_pend;
  logic [15:0] m_completed;
  logic        prev_hold;
  logic [95:0] prev_desc;

  always #5 clk = ~clk;

  aidc_lite_cmd_queue #(.DEPTH(DEPTH), .ADDR_W(32), .LEN_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready),
    .pslverr(pslverr), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_len(cmd_len),
    .cmd_done(cmd_done), .irq(irq), .dbg_state(dbg_state)
  );

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void check_bit(input string name, input logic act, input logic exp);
    check(name, {31'd0, act}, {31'd0, exp});
  endfunction

  function automatic logic [31:0] exp_rd(input logic [11:0] a);
    logic [31:0] r;
    int f;
    f = exp_q.size();
    r = 32'd0;
    case (a)
      REG_SRC:    r = m_src;
      REG_DST:    r = m_dst;
      REG_LEN:    r = m_len;
      REG_STATUS: r = {27'd0, m_ovf, (f == DEPTH), (f == 0), m_busy, m_done};
      REG_COUNT:  r = {8'd0, 8'(f), m_completed};
`ifdef AIDC_CMDQ_IRQ_EN
      REG_CTRL:   r = {23'd0, m_pend, 7'd0, m_ie};
`endif
      default:    r = 32'd0;
    endcase
    return r;
  endfunction

  function automatic logic exp_irq();
`ifdef AIDC_CMDQ_IRQ_EN
    return m_ie & m_pend;
`else
    return 1'b0;
`endif
  endfunction

  // Monitor / scoreboard: evaluates what the coming rising edge will do.
  always @(negedge clk) begin
    int   fill_now;
    logic busy_before, push_ok, done_set, exp_err;
    logic [95:0] d;
    if (!rst_n) begin
      exp_q.delete();
      m_src = 0; m_dst = 0; m_len = 0;
      m_busy = 0; m_done = 0; m_ovf = 0; m_ie = 0; m_pend = 0;
      m_completed = 0;
      prev_hold = 0;
    end else begin
      check_bit("irq_level", irq, exp_irq());
      fill_now    = exp_q.size();
      busy_before = m_busy;
      push_ok     = 0;
      done_set    = 0;
      if (prev_hold) begin
        check_bit("cmd_valid_hold", cmd_valid, 1'b1);
        check("cmd_payload_hold_src", cmd_src, prev_desc[95:64]);
        check("cmd_payload_hold_len", cmd_len, prev_desc[31:0]);
      end
      if (psel && penable) begin
        if (!pwrite) begin
          check($sformatf("rd_0x%03h", paddr), prdata, exp_rd(paddr));
          check_bit("rd_pslverr", pslverr, 1'b0);
        end else if (paddr == REG_PUSH && pwdata[0]) begin
          exp_err = (fill_now == DEPTH) || (m_len == 32'd0);
          check_bit("push_pslverr", pslverr, exp_err);
          if (fill_now == DEPTH) m_ovf = 1;
          push_ok = !exp_err;
        end else begin
          check_bit("wr_pslverr", pslverr, 1'b0);
        end
      end
      if (cmd_valid && cmd_ready) begin
        if (exp_q.size() == 0) begin
          check_bit("dispatch_without_push", 1'b1, 1'b0);
        end else begin
          d = exp_q.pop_front();
          check("dispatch_src", cmd_src, d[95:64]);
          check("dispatch_dst", cmd_dst, d[63:32]);
          check("dispatch_len", cmd_len, d[31:0]);
        end
        m_busy = 1;
      end
      if (psel && penable && pwrite && paddr == REG_CTRL) begin
        if (pwdata[4]) m_ovf = 0;
        m_ie = pwdata[0];
        if (pwdata[8]) m_pend = 0;
      end
      if (cmd_done && busy_before) begin
        m_busy = 0;
        m_completed = m_completed + 16'd1;
        m_pend = 1;
        if (fill_now == 0) done_set = 1;
      end
      if (psel && penable && pwrite) begin
        if (paddr == REG_SRC) m_src = pwdata;
        if (paddr == REG_DST) m_dst = pwdata;
        if (paddr == REG_LEN) m_len = pwdata;
      end
      if (done_set) m_done = 1;
      if (push_ok) begin
        m_done = 0;
        exp_q.push_back(d_from_stage());
      end
      prev_hold = cmd_valid && !cmd_ready;
      prev_desc = {cmd_src, cmd_dst, cmd_len};
    end
  end

  function automatic logic [95:0] d_from_stage();
    return {m_src, m_dst, m_len};
  endfunction

  // Engine: cmd_ready driver
  always @(posedge clk) begin
    #2;
    case (ready_mode)
      1:       cmd_ready = 1'b1;
      2:       cmd_ready = ($urandom_range(0, 1) == 1);
      default: cmd_ready = 1'b0;
    endcase
  end

  // Engine: completion pulses
  initial begin
    cmd_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && cmd_valid && cmd_ready) begin
        @(posedge clk);
        repeat (done_delay - 1) @(posedge clk);
        #2 cmd_done = 1'b1;
        @(posedge clk);
        #2 cmd_done = 1'b0;
      end else if (inject_ack != inject_req) begin
        @(posedge clk);
        #2 cmd_done = 1'b1;
        @(posedge clk);
        #2 cmd_done = 1'b0;
        inject_ack++;
      end
    end
  end

  task automatic apb_write(input logic [11:0] a, input logic [31:0] d, input bit pop_too, output logic err);
    @(posedge clk);
    #1 psel = 1; penable = 0; pwrite = 1; paddr = a; pwdata = d;
    @(posedge clk);
    #1 penable = 1;
    if (pop_too) ready_mode = 1;
    @(negedge clk);
    err = pslverr;
    @(posedge clk);
    #1 psel = 0; penable = 0;
    if (pop_too) ready_mode = 0;
  endtask

  task automatic apb_read(input logic [11:0] a, output logic [31:0] d);
    @(posedge clk);
    #1 psel = 1; penable = 0; pwrite = 0; paddr = a;
    @(posedge clk);
    #1 penable = 1;
    @(negedge clk);
    d = prdata;
    @(posedge clk);
    #1 psel = 0; penable = 0;
  endtask

  task automatic push_desc(input logic [31:0] s, input logic [31:0] t, input logic [31:0] l, output logic err);
    logic e;
    apb_write(REG_SRC, s, 0, e);
    apb_write(REG_DST, t, 0, e);
    apb_write(REG_LEN, l, 0, e);
    apb_write(REG_PUSH, 32'd1, 0, err);
  endtask

  task automatic wait_status(input logic [31:0] mask, input logic [31:0] value, input int max_reads, input string name);
    logic [31:0] d;
    logic hit;
    hit = 0;
    for (int i = 0; i < max_reads && !hit; i++) begin
      apb_read(REG_STATUS, d);
      if ((d & mask) == value) hit = 1;
    end
    check_bit(name, hit, 1'b1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3 rst_n = 0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1;
  endtask

  task automatic summary();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
  endtask

  initial begin
    #400000;
    n_fail++;
    $display("FAIL watchdog: got time limit reached expected test finished");
    summary();
    $finish;
  end

  initial begin
    logic        err;
    logic [31:0] d;
    logic        hit;
    logic [11:0] a;
    int          r;
    psel = 0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0; rst_n = 0;

    // Reset values
    @(negedge clk);
    check_bit("rst_cmd_valid", cmd_valid, 1'b0);
    check("rst_cmd_src", cmd_src, 32'd0);
    check("rst_cmd_len", cmd_len, 32'd0);
    check("rst_prdata", prdata, 32'd0);
    check_bit("rst_pslverr", pslverr, 1'b0);
    check_bit("rst_irq", irq, 1'b0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1;
    apb_read(REG_STATUS, d);
    check("rst_status", d, 32'h4);
    apb_read(REG_COUNT, d);
    check("rst_count", d, 32'h0);

    // 1: single descriptor, push-to-valid latency
    push_desc(32'h0001_0000, 32'h0002_0000, 32'h1000, err);
    check_bit("t1_push_err", err, 1'b0);
    @(negedge clk);
    check_bit("t1_valid_not_yet", cmd_valid, 1'b0);
    @(negedge clk);
    check_bit("t1_valid_rise", cmd_valid, 1'b1);
    check("t1_src", cmd_src, 32'h0001_0000);
    check("t1_dst", cmd_dst, 32'h0002_0000);
    check("t1_len", cmd_len, 32'h1000);
    done_delay = 3;
    ready_mode = 1;
    wait_status(32'h7, 32'h5, 30, "t1_done_timeout");
    apb_read(REG_STATUS, d);
    check("t1_status", d, 32'h5);
    apb_read(REG_COUNT, d);
    check("t1_count", {16'd0, d[15:0]}, 32'd1);
    ready_mode = 0;
    do_reset();

    // 2: overflow with 9 pushes, engine stalled
    for (int i = 0; i < 9; i++) begin
      push_desc(32'h1000 * (i + 1), 32'h8000_0000 + i, 32'h40 + i, err);
      check_bit($sformatf("t2_push%0d_err", i), err, (i == 8));
    end
    apb_read(REG_STATUS, d);
    check("t2_status_full_ovf", d, 32'h18);
    apb_read(REG_COUNT, d);
    check("t2_count_fill8", d, 32'h0008_0000);
    apb_write(REG_CTRL, 32'h10, 0, err);
    apb_read(REG_STATUS, d);
    check("t2_ovf_cleared", d, 32'h08);

    // 4a: push into full queue on the cycle of a pop
    done_delay = 5;
    apb_write(REG_PUSH, 32'd1, 1, err);
    check_bit("t4_full_pop_err", err, 1'b1);
    apb_read(REG_COUNT, d);
    check("t4_fill_after_pop", {24'd0, d[23:16]}, 32'd7);
    apb_write(REG_CTRL, 32'h10, 0, err);

    // 3: drain 8 descriptors, ready held, done 5 cycles after accept
    ready_mode = 1;
    wait_status(32'h7, 32'h5, 60, "t3_drain_timeout");
    apb_read(REG_COUNT, d);
    check("t3_count", d, 32'h0000_0008);
    apb_read(REG_STATUS, d);
    check("t3_status", d, 32'h5);

    // 4b: push coincident with pop at fill=3
    ready_mode = 0;
    for (int i = 0; i < 3; i++) begin
      push_desc(32'hA000 + i, 32'hB000 + i, 32'h10 + i, err);
      check_bit("t4b_push_err", err, 1'b0);
    end
    apb_read(REG_COUNT, d);
    check("t4b_fill3", d, 32'h0003_0008);
    apb_write(REG_PUSH, 32'd1, 1, err);
    check_bit("t4b_push_pop_err", err, 1'b0);
    apb_read(REG_COUNT, d);
    check("t4b_fill_stays3", {24'd0, d[23:16]}, 32'd3);
    ready_mode = 1;
    wait_status(32'h7, 32'h5, 80, "t4b_drain_timeout");

    // 5: LEN=0 push and stray cmd_done
    ready_mode = 0;
    apb_write(REG_LEN, 32'd0, 0, err);
    apb_write(REG_PUSH, 32'd1, 0, err);
    check_bit("t5_len0_err", err, 1'b1);
    repeat (3) begin
      @(negedge clk);
      check_bit("t5_no_valid", cmd_valid, 1'b0);
    end
    apb_read(REG_STATUS, d);
    check("t5_status_no_ovf", d, 32'h5);
    inject_req++;
    hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(negedge clk);
      if (inject_ack == inject_req) hit = 1;
    end
    check_bit("t5_inject_timeout", hit, 1'b1);
    apb_read(REG_COUNT, d);
    check("t5_count_unchanged", d, 32'h0000_000C);

    // Randomized traffic
    ready_mode = 2;
    for (int i = 0; i < 250; i++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2, 3: push_desc($urandom, $urandom,
                              ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom_range(1, 65535)), err);
        4, 5: begin
          a = 12'(4 * $urandom_range(0, 8));
          apb_read(a, d);
        end
        6: apb_write(REG_CTRL, $urandom & 32'h111, 0, err);
        7: apb_write(12'(4 * $urandom_range(4, 40)), $urandom & 32'hFFFF_FFFE, 0, err);
        8: done_delay = $urandom_range(1, 6);
        default: apb_write(REG_PUSH, $urandom & 32'hFFFF_FFFE, 0, err);
      endcase
    end
    ready_mode = 1;
    wait_status(32'h6, 32'h4, 100, "rand_drain_timeout");

`ifdef AIDC_CMDQ_IRQ_EN
    apb_write(REG_CTRL, 32'h101, 0, err);
    done_delay = 3;
    apb_write(REG_LEN, 32'h20, 0, err);
    apb_write(REG_PUSH, 32'd1, 0, err);
    hit = 0;
    for (int i = 0; i < 40 && !hit; i++) begin
      @(negedge clk);
      if (irq) hit = 1;
    end
    check_bit("irq_raise", hit, 1'b1);
    apb_write(REG_CTRL, 32'h101, 0, err);
    @(negedge clk);
    check_bit("irq_cleared", irq, 1'b0);
`else
    apb_write(REG_CTRL, 32'h111, 0, err);
    apb_read(REG_CTRL, d);
    check("ctrl_reads_zero", d, 32'd0);
    check_bit("irq_tied_low", irq, 1'b0);
`endif

    // 6: reset while a descriptor is running
    wait_status(32'h6, 32'h4, 40, "t6_idle_timeout");
    ready_mode = 1;
    done_delay = 30;
    push_desc(32'hCAFE_0000, 32'hBEEF_0000, 32'h80, err);
    hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(negedge clk);
      if (dbg_state == RUN) hit = 1;
    end
    check_bit("t6_reach_run", hit, 1'b1);
    @(posedge clk);
    #3 rst_n = 0;
    #1;
    check_bit("t6_valid_async", cmd_valid, 1'b0);
    check("t6_src_async", cmd_src, 32'd0);
    check("t6_dst_async", cmd_dst, 32'd0);
    check("t6_len_async", cmd_len, 32'd0);
    check_bit("t6_irq_async", irq, 1'b0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1;
    apb_read(REG_STATUS, d);
    check("t6_status_after", d, 32'h4);
    repeat (40) @(posedge clk);
    apb_read(REG_COUNT, d);
    check("t6_count_after", d, 32'h0);

    repeat (5) @(posedge clk);
    summary();
    $finish;
  end

endmodule
